// File: rtl/fib_sched.sv
// fib_sched: round-robin scheduler that fetches two seeds from a table and drives an external Fibonacci datapath.
module fib_sched #(
  parameter int WDOG_SLACK = 2
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic [1:0]  req,
  input  logic [11:0] req_start0,
  input  logic [11:0] req_start1,
  input  logic [11:0] req_index0,
  input  logic [11:0] req_index1,
  output logic [1:0]  grant,
  output logic [1:0]  done,
  output logic [15:0] result,
  output logic        error,
  output logic        busy,
  output logic        mem_rd,
  output logic [11:0] mem_addr,
  input  logic [15:0] mem_rdata,
  output logic        dp_reset,
  output logic [1:0]  dp_stage,
  output logic [15:0] dp_currentnum,
  output logic [11:0] dp_address,
  output logic [11:0] dp_number,
  input  logic        dp_ready,
  input  logic [15:0] dp_out
);
  typedef enum logic [2:0] {IDLE, FETCH0, FETCH1, LOAD1, LOAD2, RUN, DONE} state_t;
  state_t      state_q, state_d;
  logic        fav1_q, fav1_d;
  logic [11:0] a_q, a_d, n_q, n_d;
  logic [15:0] seed0_q, seed0_d;
  logic [12:0] wd_q, wd_d;
  logic [1:0]  grant_q, grant_d, done_q, done_d, dp_stage_q, dp_stage_d;
  logic [15:0] result_q, result_d, dp_currentnum_q, dp_currentnum_d;
  logic        error_q, error_d, busy_q, busy_d, mem_rd_q, mem_rd_d, dp_reset_q, dp_reset_d;
  logic [11:0] mem_addr_q, mem_addr_d, dp_address_q, dp_address_d, dp_number_q, dp_number_d;
  logic        pick;
  logic [11:0] acc_a, acc_n;
  logic [12:0] wd_inc, wd_limit;
  // requester 1 wins only when alone or when it is its turn on a tie
  assign pick     = req[1] & (~req[0] | fav1_q);
  assign acc_a    = pick ? req_start1 : req_start0;
  assign acc_n    = pick ? req_index1 : req_index0;
  assign wd_inc   = wd_q + 13'd1;
  assign wd_limit = {1'b0, n_q - a_q} + 13'(WDOG_SLACK);
  always_comb begin
    state_d         = state_q;
    fav1_d          = fav1_q;
    a_d             = a_q;
    n_d             = n_q;
    seed0_d         = seed0_q;
    wd_d            = wd_q;
    grant_d         = grant_q;
    done_d          = 2'b00;
    result_d        = result_q;
    error_d         = error_q;
    busy_d          = busy_q;
    mem_rd_d        = 1'b0;
    mem_addr_d      = mem_addr_q;
    dp_reset_d      = 1'b0;
    dp_stage_d      = 2'd1;
    dp_currentnum_d = dp_currentnum_q;
    dp_address_d    = dp_address_q;
    dp_number_d     = dp_number_q;
    case (state_q)
      IDLE: if (|req) begin
        grant_d     = pick ? 2'b10 : 2'b01;
        busy_d      = 1'b1;
        fav1_d      = ~pick;
        a_d         = acc_a;
        n_d         = acc_n;
        dp_number_d = acc_n;
        if (acc_n < acc_a) begin
          state_d  = DONE;
          done_d   = pick ? 2'b10 : 2'b01;
          error_d  = 1'b1;
          result_d = 16'd0;
        end else begin
          state_d    = FETCH0;
          dp_reset_d = 1'b1;
          mem_rd_d   = 1'b1;
          mem_addr_d = acc_a;
        end
      end
      FETCH0: begin
        state_d    = FETCH1;
        mem_rd_d   = 1'b1;
        mem_addr_d = a_q + 12'd1;
      end
      FETCH1: begin
        state_d         = LOAD1;
        seed0_d         = mem_rdata;
        dp_currentnum_d = mem_rdata;
      end
      // a zero-length job finishes here with the first seed as its answer
      LOAD1: if (n_q == a_q) begin
        state_d  = DONE;
        done_d   = grant_q;
        result_d = seed0_q;
        error_d  = 1'b0;
      end else begin
        state_d         = LOAD2;
        dp_stage_d      = 2'd2;
        dp_currentnum_d = mem_rdata;
        dp_address_d    = a_q + 12'd1;
      end
      LOAD2: begin
        state_d    = RUN;
        dp_stage_d = 2'd0;
        wd_d       = 13'd0;
      end
      RUN: if (dp_ready) begin
        state_d  = DONE;
        done_d   = grant_q;
        result_d = dp_out;
        error_d  = 1'b0;
      end else if (wd_inc == wd_limit) begin
        state_d  = DONE;
        done_d   = grant_q;
        result_d = 16'd0;
        error_d  = 1'b1;
      end else begin
        dp_stage_d = 2'd0;
        wd_d       = &wd_q ? wd_q : wd_inc;
      end
      DONE: begin
        state_d = IDLE;
        grant_d = 2'b00;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q         <= IDLE;
      fav1_q          <= 1'b0;
      a_q             <= 12'd0;
      n_q             <= 12'd0;
      seed0_q         <= 16'd0;
      wd_q            <= 13'd0;
      grant_q         <= 2'b00;
      done_q          <= 2'b00;
      result_q        <= 16'd0;
      error_q         <= 1'b0;
      busy_q          <= 1'b0;
      mem_rd_q        <= 1'b0;
      mem_addr_q      <= 12'd0;
      dp_reset_q      <= 1'b1;
      dp_stage_q      <= 2'd1;
      dp_currentnum_q <= 16'd0;
      dp_address_q    <= 12'd0;
      dp_number_q     <= 12'd0;
    end else begin
      state_q         <= state_d;
      fav1_q          <= fav1_d;
      a_q             <= a_d;
      n_q             <= n_d;
      seed0_q         <= seed0_d;
      wd_q            <= wd_d;
      grant_q         <= grant_d;
      done_q          <= done_d;
      result_q        <= result_d;
      error_q         <= error_d;
      busy_q          <= busy_d;
      mem_rd_q        <= mem_rd_d;
      mem_addr_q      <= mem_addr_d;
      dp_reset_q      <= dp_reset_d;
      dp_stage_q      <= dp_stage_d;
      dp_currentnum_q <= dp_currentnum_d;
      dp_address_q    <= dp_address_d;
      dp_number_q     <= dp_number_d;
    end
  end
  assign grant         = grant_q;
  assign done          = done_q;
  assign result        = result_q;
  assign error         = error_q;
  assign busy          = busy_q;
  assign mem_rd        = mem_rd_q;
  assign mem_addr      = mem_addr_q;
  assign dp_reset      = dp_reset_q;
  assign dp_stage      = dp_stage_q;
  assign dp_currentnum = dp_currentnum_q;
  assign dp_address    = dp_address_q;
  assign dp_number     = dp_number_q;
endmodule

// File: tb/tb_fib_sched.sv
// tb_fib_sched: seed-table and datapath models around fib_sched, with a job scoreboard checked on each done pulse.
module tb_fib_sched;
  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  req = 2'b00;
  logic [11:0] req_start0 = 12'd0, req_start1 = 12'd0, req_index0 = 12'd0, req_index1 = 12'd0;
  logic [1:0]  grant, done, dp_stage;
  logic [15:0] result, dp_currentnum, dp_out;
  logic        error, busy, mem_rd, dp_reset, dp_ready;
  logic [11:0] mem_addr, dp_address, dp_number;
  logic [15:0] mem_rdata = 16'd0;
  logic [15:0] mem [4096];
  logic [15:0] n1 = 16'd0, n2 = 16'd0;
  logic [11:0] cnt = 12'd0;
  logic        rdy = 1'b0;
  logic        dp_kill = 1'b0;

  always #5 CLK = ~CLK;

  fib_sched #(.WDOG_SLACK(2)) dut (
    .CLK(CLK), .reset(reset), .req(req),
    .req_start0(req_start0), .req_start1(req_start1),
    .req_index0(req_index0), .req_index1(req_index1),
    .grant(grant), .done(done), .result(result), .error(error), .busy(busy),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .dp_reset(dp_reset), .dp_stage(dp_stage), .dp_currentnum(dp_currentnum),
    .dp_address(dp_address), .dp_number(dp_number), .dp_ready(dp_ready), .dp_out(dp_out)
  );

  // seed table: data valid the cycle after the strobe
  always @(posedge CLK) if (mem_rd) mem_rdata <= mem[mem_addr];

  // datapath: one addition per cycle, ready one cycle after the counter reaches the stop value
  always @(posedge CLK) begin
    if (dp_reset) rdy <= 1'b0;
    else if (dp_stage == 2'd1) n1 <= dp_currentnum;
    else if (dp_stage == 2'd2) begin n2 <= dp_currentnum; cnt <= dp_address; end
    else if (dp_stage == 2'd0 && !rdy) begin
      if (cnt == dp_number) rdy <= 1'b1;
      else begin n1 <= n2; n2 <= n1 + n2; cnt <= cnt + 12'd1; end
    end
  end
  assign dp_ready = rdy & ~dp_kill;
  assign dp_out   = n2;

  typedef struct { logic [1:0] grant; logic [15:0] res; logic err; int lat; logic s0; logic mr; } exp_t;
  typedef struct { bit r; logic [11:0] a; logic [11:0] n; bit kill; bit drop; logic [15:0] res; logic err; int lat; } vec_t;
  exp_t sbq[$];
  exp_t em;
  vec_t vecs[13];
  int tests = 0, fails = 0, cyc = 0, g_cyc = 0, done_cyc = -100, gap = 0;
  logic s0 = 1'b0, mr = 1'b0;
  logic [1:0] prev_grant = 2'b00;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", nm, act, expv);
    end
  endtask

  initial forever begin @(posedge CLK); cyc++; end

  initial forever begin
    @(negedge CLK);
    if (grant != 2'b00 && prev_grant == 2'b00) begin gap = cyc - done_cyc; g_cyc = cyc; s0 = 1'b0; mr = 1'b0; end
    if (grant != 2'b00) begin if (dp_stage == 2'd0) s0 = 1'b1; if (mem_rd) mr = 1'b1; end
    if (done != 2'b00) begin
      done_cyc = cyc;
      if (sbq.size() == 0) chk("spurious_done", 64'(done), 64'd0);
      else begin
        em = sbq.pop_front();
        chk("done_bit", 64'(done), 64'(em.grant));
        chk("done_grant", 64'(grant), 64'(em.grant));
        chk("result", 64'(result), 64'(em.res));
        chk("error", 64'(error), 64'(em.err));
        chk("latency", 64'(cyc - g_cyc), 64'(em.lat));
        chk("saw_stage0", 64'(s0), 64'(em.s0));
        chk("saw_mem_rd", 64'(mr), 64'(em.mr));
      end
    end
    prev_grant = grant;
  end

  task automatic wait_for(input bit on_done, input string nm);
    for (int k = 0; k < 300; k++) begin
      if (on_done ? (done != 2'b00) : (grant != 2'b00)) return;
      @(negedge CLK);
    end
    tests++; fails++;
    $display("FAIL %s: got no event within 300 cycles, required one", nm);
  endtask

  task automatic push(input logic [1:0] g, input logic [15:0] res, input logic err, input int lat, input logic s, input logic m);
    exp_t x;
    x.grant = g; x.res = res; x.err = err; x.lat = lat; x.s0 = s; x.mr = m;
    sbq.push_back(x);
  endtask

  task automatic run_job(input vec_t v);
    push(v.r ? 2'b10 : 2'b01, v.res, v.err, v.lat, v.n > v.a, v.n >= v.a);
    dp_kill = v.kill;
    if (v.r) begin req_start1 = v.a; req_index1 = v.n; end
    else begin req_start0 = v.a; req_index0 = v.n; end
    req[v.r] = 1'b1;
    wait_for(1'b0, "grant");
    // disturb the inputs after acceptance; the job must use its latched copy
    if (v.r) begin req_start1 = 12'($urandom); req_index1 = 12'($urandom); end
    else begin req_start0 = 12'($urandom); req_index0 = 12'($urandom); end
    if (v.drop) req[v.r] = 1'b0;
    wait_for(1'b1, "done");
    req[v.r] = 1'b0;
    dp_kill = 1'b0;
    @(negedge CLK);
  endtask

  task automatic tie(input logic [11:0] a0, input logic [11:0] n0, input logic [15:0] r0, input int l0,
                     input logic [11:0] a1, input logic [11:0] n1v, input logic [15:0] r1, input int l1);
    push(2'b01, r0, 1'b0, l0, 1'b1, 1'b1);
    push(2'b10, r1, 1'b0, l1, 1'b1, 1'b1);
    req_start0 = a0; req_index0 = n0; req_start1 = a1; req_index1 = n1v;
    req = 2'b11;
    wait_for(1'b0, "tie_grant");
    chk("tie_first_grant", 64'(grant), 64'd1);
    wait_for(1'b1, "tie_done0");
    req[0] = 1'b0;
    @(negedge CLK);
    chk("tie_idle_between", 64'(grant), 64'd0);
    wait_for(1'b1, "tie_done1");
    chk("tie_gap", 64'(gap), 64'd2);
    req = 2'b00;
    @(negedge CLK);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    mem[0] = 16'd0;
    mem[1] = 16'd1;
    for (int i = 2; i < 4096; i++) mem[i] = mem[i-1] + mem[i-2];
    mem[4095] = 16'hBEEF;
    vecs[0]  = '{1'b0, 12'd5,    12'd10,   1'b0, 1'b0, 16'd55,    1'b0, 10};
    vecs[1]  = '{1'b0, 12'd7,    12'd7,    1'b0, 1'b0, 16'd13,    1'b0, 3};
    vecs[2]  = '{1'b1, 12'd9,    12'd4,    1'b0, 1'b0, 16'd0,     1'b1, 0};
    vecs[3]  = '{1'b1, 12'd2,    12'd6,    1'b1, 1'b0, 16'd0,     1'b1, 10};
    vecs[4]  = '{1'b1, 12'd0,    12'd1,    1'b0, 1'b1, 16'd1,     1'b0, 6};
    vecs[5]  = '{1'b0, 12'd0,    12'd0,    1'b0, 1'b0, 16'd0,     1'b0, 3};
    vecs[6]  = '{1'b0, 12'd10,   12'd24,   1'b0, 1'b1, 16'd46368, 1'b0, 19};
    vecs[7]  = '{1'b1, 12'd20,   12'd30,   1'b0, 1'b0, 16'd45608, 1'b0, 15};
    vecs[8]  = '{1'b0, 12'd4095, 12'd4095, 1'b0, 1'b0, 16'hBEEF,  1'b0, 3};
    vecs[9]  = '{1'b1, 12'd4094, 12'd4095, 1'b0, 1'b0, 16'hBEEF,  1'b0, 6};
    vecs[10] = '{1'b0, 12'd4095, 12'd0,    1'b0, 1'b0, 16'd0,     1'b1, 0};
    vecs[11] = '{1'b1, 12'd1,    12'd3,    1'b0, 1'b0, 16'd2,     1'b0, 7};
    vecs[12] = '{1'b0, 12'd3,    12'd4,    1'b1, 1'b0, 16'd0,     1'b1, 7};
    repeat (3) @(negedge CLK);
    chk("rst_ctl", 64'({grant, done, error, busy, mem_rd, dp_reset, dp_stage}), 64'b0000000101);
    chk("rst_data", 64'({result, dp_currentnum}), 64'd0);
    chk("rst_addr", 64'({mem_addr, dp_address, dp_number}), 64'd0);
    reset = 1'b0;
    tie(12'd0, 12'd3, 16'd2, 8, 12'd0, 12'd4, 16'd3, 9);
    tie(12'd1, 12'd2, 16'd1, 6, 12'd2, 12'd5, 16'd5, 8);
    for (int i = 0; i < 13; i++) run_job(vecs[i]);
    req_start0 = 12'd0; req_index0 = 12'd20; req = 2'b01;
    wait_for(1'b0, "midrun_grant");
    repeat (8) @(negedge CLK);
    chk("midrun_in_run", 64'(dp_stage), 64'd0);
    reset = 1'b1;
    @(negedge CLK);
    chk("midrun_rst_ctl", 64'({grant, done, error, busy, mem_rd, dp_reset, dp_stage}), 64'b0000000101);
    chk("midrun_rst_data", 64'({result, dp_currentnum}), 64'd0);
    chk("midrun_rst_addr", 64'({mem_addr, dp_address, dp_number}), 64'd0);
    reset = 1'b0;
    req = 2'b00;
    @(negedge CLK);
    chk("idle_after_reset", 64'({busy, grant}), 64'd0);
    run_job(vecs[0]);
    run_job(vecs[7]);
    repeat (3) @(negedge CLK);
    chk("scoreboard_empty", 64'(sbq.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
